// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared encodings, FSM state type and iteration count for the multiply/divide unit
package md_pkg;

  localparam int ITER = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } md_state_e;

  // Divide ops set the upper opcode bit; signed ops clear the lower one.
  function automatic logic op_is_div(input md_op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/md_step.sv
// rtl/md_step.sv - one combinational shift-add (multiply) or restoring shift-subtract (divide) iteration
module md_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_operand,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;

  // Multiply: hi accumulates the multiplicand when the multiplier LSB is set, then {carry,hi,lo} shifts right.
  // Divide: {rem,dividend MSB} is trial-compared against the divisor; remainder stays below the divisor,
  // so a 32-bit subtraction suffices once the compare passes.
  always_comb begin
    w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_operand} : '0);
    w_shift = {i_hi, i_lo[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, i_operand});
    w_sub   = w_shift[WIDTH-1:0] - i_operand;
    if (i_is_div) begin
      o_hi = w_ge ? w_sub : w_shift[WIDTH-1:0];
      o_lo = {i_lo[WIDTH-2:0], w_ge};
    end else begin
      o_hi = w_sum[WIDTH:1];
      o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32-cycle multiply/divide unit with architectural HI/LO registers
module mult_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] rs_data_E,
  input  logic [WIDTH-1:0] rt_data_E,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             md_flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e        r_state;
  md_state_e        w_state_next;
  logic [5:0]       r_cnt;
  md_op_e           r_op;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_opb;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  md_op_e           w_op_in;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_last;
  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  assign w_op_in = md_op_e'(md_op);
  assign w_last  = (r_cnt == 6'(ITER - 1));
  assign busy    = (r_state == ST_CALC);
  assign done    = r_done;
  assign hi      = r_hi;
  assign lo      = r_lo;

  md_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div  (op_is_div(r_op)),
    .i_hi      (r_acc_hi),
    .i_lo      (r_acc_lo),
    .i_operand (r_opb),
    .o_hi      (w_step_hi),
    .o_lo      (w_step_lo)
  );

  // Operand sign pre-conversion: signed ops iterate on magnitudes.
  always_comb begin
    w_a_neg = op_is_signed(w_op_in) & rs_data_E[WIDTH-1];
    w_b_neg = op_is_signed(w_op_in) & rt_data_E[WIDTH-1];
    w_a_mag = w_a_neg ? -rs_data_E : rs_data_E;
    w_b_mag = w_b_neg ? -rt_data_E : rt_data_E;
  end

  // Sign post-correction of the final iteration's output; zero divisor forces an all-ones quotient.
  always_comb begin
    w_prod = {w_step_hi, w_step_lo};
    if (r_neg_q) begin
      w_prod = -w_prod;
    end
    if (op_is_div(r_op)) begin
      w_res_lo = r_div0 ? '1 : (r_neg_q ? -w_step_lo : w_step_lo);
      w_res_hi = r_neg_r ? -w_step_hi : w_step_hi;
    end else begin
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: flush always returns to IDLE; CALC leaves after the last iteration.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start && !md_flush) w_state_next = ST_CALC;
      ST_CALC: if (md_flush || w_last) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath, iteration counter and HI/LO: launch on start, iterate in CALC, commit on the last edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_op     <= MD_MULT;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_opb    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (md_flush) begin
        r_cnt <= '0;
      end else if (r_state == ST_IDLE) begin
        if (start) begin
          r_cnt    <= '0;
          r_op     <= w_op_in;
          r_acc_hi <= '0;
          r_acc_lo <= w_a_mag;
          r_opb    <= w_b_mag;
          r_neg_q  <= w_a_neg ^ w_b_neg;
          r_neg_r  <= w_a_neg;
          r_div0   <= (rt_data_E == '0);
        end else begin
          if (mthi) r_hi <= rs_data_E;
          if (mtlo) r_lo <= rs_data_E;
        end
      end else begin
        r_acc_hi <= w_step_hi;
        r_acc_lo <= w_step_lo;
        if (w_last) begin
          r_cnt  <= '0;
          r_hi   <= w_res_hi;
          r_lo   <= w_res_lo;
          r_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] rs_data_E;
  logic [31:0] rt_data_E;
  logic        mthi;
  logic        mtlo;
  logic        md_flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  int pulses;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .md_op     (md_op),
    .rs_data_E (rs_data_E),
    .rt_data_E (rt_data_E),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .md_flush  (md_flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; md_op = op; rs_data_E = a; rt_data_E = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int c;
    launch(op, a, b);
    wait_idle(c);
    chk({tag, "_busy_cycles"}, 64'(c), 64'd32);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_hi"}, 64'(hi), 64'(ehi));
    chk({tag, "_lo"}, 64'(lo), 64'(elo));
    @(negedge clk);
    chk({tag, "_done_clear"}, 64'(done), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; md_op = 2'b00; rs_data_E = '0; rt_data_E = '0;
    mthi = 1'b0; mtlo = 1'b0; md_flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    reset = 1'b0;

    run_op("mult_neg",   2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("multu_max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("divu_100_7", 2'b11, 32'd100,      32'd7,        32'd2,        32'd14);
    run_op("div_neg7_2", 2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_by0",    2'b10, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF);
    run_op("divu_by0",   2'b11, 32'h87654321, 32'd0,        32'h87654321, 32'hFFFFFFFF);
    run_op("div_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("mult_mixed", 2'b00, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006);

    // mthi in IDLE: hi updates next edge, lo untouched, no done
    @(negedge clk);
    mthi = 1'b1; rs_data_E = 32'h55;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h55);
    chk("mthi_lo", 64'(lo), 64'h6);
    chk("mthi_done", 64'(done), 64'd0);

    // preload HI/LO, then flush mid-operation
    mthi = 1'b1; mtlo = 1'b1; rs_data_E = 32'hA5A5A5A5;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("preload_lo", 64'(lo), 64'hA5A5A5A5);
    launch(2'b01, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    md_flush = 1'b1;
    @(negedge clk);
    md_flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    chk("flush_hi", 64'(hi), 64'hA5A5A5A5);
    chk("flush_lo", 64'(lo), 64'hA5A5A5A5);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("flush_no_done", 64'(pulses), 64'd0);

    // flush overrides start and mthi in IDLE
    md_flush = 1'b1; start = 1'b1; mthi = 1'b1; rs_data_E = 32'h11;
    @(negedge clk);
    md_flush = 1'b0; start = 1'b0; mthi = 1'b0;
    chk("flush_ovr_busy", 64'(busy), 64'd0);
    chk("flush_ovr_hi", 64'(hi), 64'hA5A5A5A5);

    // start + mthi while busy are ignored
    launch(2'b01, 32'd6, 32'd7);
    repeat (5) @(negedge clk);
    start = 1'b1; md_op = 2'b11; mthi = 1'b1; rs_data_E = 32'hDEAD; rt_data_E = 32'd1;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    chk("busy_mthi_hi", 64'(hi), 64'hA5A5A5A5);
    wait_idle(cyc);
    chk("busy_ign_cycles", 64'(cyc), 64'd26);
    chk("busy_ign_done", 64'(done), 64'd1);
    chk("busy_ign_hi", 64'(hi), 64'd0);
    chk("busy_ign_lo", 64'(lo), 64'd42);

    // start with mthi in IDLE: start wins
    @(negedge clk);
    start = 1'b1; mthi = 1'b1; md_op = 2'b01; rs_data_E = 32'd2; rt_data_E = 32'd3;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    chk("start_win_hi", 64'(hi), 64'd0);
    chk("start_win_busy", 64'(busy), 64'd1);
    wait_idle(cyc);
    chk("start_win_lo", 64'(lo), 64'd6);

    // reset mid-operation, then a normal operation
    launch(2'b01, 32'hFFFF, 32'hFFFF);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    run_op("post_rst", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
